dma_dsc_cache_ram: RTL and testbench

//  Parametrised descriptor cache for the DMA controller: DEPTH entries of DATA_W bits, one write

---
 rtl/dma_dsc_cache_pkg.sv | 20 ++
 rtl/dma_dsc_cache_mem.sv | 28 ++
 rtl/dma_dsc_cache_ram.sv | 118 +++++++++++
 tb/tb_dma_dsc_cache_ram.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/dma_dsc_cache_pkg.sv
// Shared constants, default-shape typedefs and helpers for the DMA descriptor cache.
package dma_dsc_cache_pkg;

  localparam int DSC_DATA_W  = 13;
  localparam int DSC_DEPTH   = 4;
  localparam int RD_LAT_ADDR = 1;
  localparam int RD_LAT_DATA = 2;

  typedef logic [DSC_DATA_W-1:0] dsc_entry_t;
  typedef logic [DSC_DEPTH-1:0]  dsc_vld_vec_t;

  // Number of set bits in a valid vector of up to 64 entries.
  function automatic logic [6:0] popcount(input logic [63:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) c = c + {6'd0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/dma_dsc_cache_mem.sv
// Plain 1W1R descriptor storage: no reset, read port samples at the clock edge (read-first).
module dma_dsc_cache_mem
  import dma_dsc_cache_pkg::*;
#(
  parameter  int DATA_W = DSC_DATA_W,
  parameter  int DEPTH  = DSC_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_w_en,
  input  logic [ADDR_W-1:0] i_w_addr,
  input  logic [DATA_W-1:0] i_w_data,
  input  logic              i_r_en,
  input  logic [ADDR_W-1:0] i_r_addr,
  output logic [DATA_W-1:0] o_r_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_w_en) r_mem[i_w_addr] <= i_w_data;
    if (i_r_en) r_q <= r_mem[i_r_addr];
  end

  assign o_r_data = r_q;

endmodule

// File: rtl/dma_dsc_cache_ram.sv
// Descriptor cache: storage plus per-entry valid bits, invalidate, forwarding and read pipe.
module dma_dsc_cache_ram
  import dma_dsc_cache_pkg::*;
#(
  parameter  int DATA_W = DSC_DATA_W,
  parameter  int DEPTH  = DSC_DEPTH,
  parameter  int RD_LAT = RD_LAT_ADDR,
  parameter  bit FWD_EN = 1'b1,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_srst_n,
  input  logic              i_w_en,
  input  logic [ADDR_W-1:0] i_w_addr,
  input  logic [DATA_W-1:0] i_w_data,
  input  logic              i_r_en,
  input  logic [ADDR_W-1:0] i_r_addr,
  output logic [DATA_W-1:0] o_r_data,
  output logic              o_r_valid,
  output logic              o_r_hit,
  input  logic              i_inv_en,
  input  logic [ADDR_W-1:0] i_inv_addr,
  input  logic              i_inv_all,
  output logic [DEPTH-1:0]  o_valid_vec,
  output logic [ADDR_W:0]   o_occ_cnt
);

  localparam int OCC_W = ADDR_W + 1;

  logic [DEPTH-1:0]  r_valid, w_valid_nxt;
  logic [ADDR_W:0]   r_occ;
  logic [DATA_W-1:0] w_mem_q, w_data1, r_wdata1;
  logic              w_col, r_vld1, r_hit1, r_fwd1, r_zero;

  dma_dsc_cache_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .i_clk    (i_clk),
    .i_w_en   (i_w_en),
    .i_w_addr (i_w_addr),
    .i_w_data (i_w_data),
    .i_r_en   (i_r_en),
    .i_r_addr (i_r_addr),
    .o_r_data (w_mem_q)
  );

  assign w_col = i_r_en && i_w_en && (i_r_addr == i_w_addr);

  // Write is applied last so it wins over either invalidate on the same entry.
  always_comb begin
    w_valid_nxt = r_valid;
    if (i_inv_all) w_valid_nxt = '0;
    if (i_inv_en)  w_valid_nxt[i_inv_addr] = 1'b0;
    if (i_w_en)    w_valid_nxt[i_w_addr] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_srst_n) begin
      r_valid <= '0;
      r_occ   <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      r_occ   <= OCC_W'(popcount(64'(w_valid_nxt)));
    end
  end

  // Stage 1: hit bit and forward select captured with the request.
  always_ff @(posedge i_clk) begin
    if (!i_srst_n) begin
      r_vld1 <= 1'b0;
      r_hit1 <= 1'b0;
      r_zero <= 1'b1;
    end else begin
      r_vld1 <= i_r_en;
      if (i_r_en) begin
        r_hit1 <= (FWD_EN && w_col) ? 1'b1 : r_valid[i_r_addr];
        r_zero <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_r_en) begin
      r_fwd1   <= FWD_EN && w_col;
      r_wdata1 <= i_w_data;
    end
  end

  // r_zero presents zero data after reset until the first read result lands.
  assign w_data1 = r_zero ? '0 : (r_fwd1 ? r_wdata1 : w_mem_q);

  if (RD_LAT == RD_LAT_DATA) begin : g_lat2
    logic              r_vld2, r_hit2;
    logic [DATA_W-1:0] r_data2;
    always_ff @(posedge i_clk) begin
      if (!i_srst_n) begin
        r_vld2  <= 1'b0;
        r_hit2  <= 1'b0;
        r_data2 <= '0;
      end else begin
        r_vld2 <= r_vld1;
        if (r_vld1) begin
          r_hit2  <= r_hit1;
          r_data2 <= w_data1;
        end
      end
    end
    assign o_r_valid = r_vld2;
    assign o_r_hit   = r_vld2 & r_hit2;
    assign o_r_data  = r_data2;
  end else begin : g_lat1
    assign o_r_valid = r_vld1;
    assign o_r_hit   = r_vld1 & r_hit1;
    assign o_r_data  = w_data1;
  end

  assign o_valid_vec = r_valid;
  assign o_occ_cnt   = r_occ;

endmodule

// File: tb/tb_dma_dsc_cache_ram.sv
// Directed and random checks of four cache configurations against a behavioural model.
module tb_dma_dsc_cache_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        srst_n, w_en, r_en, inv_en, inv_all;
  logic [3:0]  w_addr, r_addr, inv_addr;
  logic [31:0] w_data;
  int total = 0, bad = 0;

  logic [12:0] a_rd, b_rd, c_rd;
  logic        a_rv, b_rv, c_rv, a_rh, b_rh, c_rh, d_rv, d_rh;
  logic [3:0]  a_vv, b_vv, c_vv;
  logic [2:0]  a_oc, b_oc, c_oc;
  logic [31:0] d_rd;
  logic [15:0] d_vv;
  logic [4:0]  d_oc;

  dma_dsc_cache_ram #(.DATA_W(13), .DEPTH(4), .RD_LAT(1), .FWD_EN(1'b1)) u_a (
    .i_clk(clk), .i_srst_n(srst_n), .i_w_en(w_en), .i_w_addr(w_addr[1:0]),
    .i_w_data(w_data[12:0]), .i_r_en(r_en), .i_r_addr(r_addr[1:0]), .o_r_data(a_rd),
    .o_r_valid(a_rv), .o_r_hit(a_rh), .i_inv_en(inv_en), .i_inv_addr(inv_addr[1:0]),
    .i_inv_all(inv_all), .o_valid_vec(a_vv), .o_occ_cnt(a_oc));

  dma_dsc_cache_ram #(.DATA_W(13), .DEPTH(4), .RD_LAT(1), .FWD_EN(1'b0)) u_b (
    .i_clk(clk), .i_srst_n(srst_n), .i_w_en(w_en), .i_w_addr(w_addr[1:0]),
    .i_w_data(w_data[12:0]), .i_r_en(r_en), .i_r_addr(r_addr[1:0]), .o_r_data(b_rd),
    .o_r_valid(b_rv), .o_r_hit(b_rh), .i_inv_en(inv_en), .i_inv_addr(inv_addr[1:0]),
    .i_inv_all(inv_all), .o_valid_vec(b_vv), .o_occ_cnt(b_oc));

  dma_dsc_cache_ram #(.DATA_W(13), .DEPTH(4), .RD_LAT(2), .FWD_EN(1'b1)) u_c (
    .i_clk(clk), .i_srst_n(srst_n), .i_w_en(w_en), .i_w_addr(w_addr[1:0]),
    .i_w_data(w_data[12:0]), .i_r_en(r_en), .i_r_addr(r_addr[1:0]), .o_r_data(c_rd),
    .o_r_valid(c_rv), .o_r_hit(c_rh), .i_inv_en(inv_en), .i_inv_addr(inv_addr[1:0]),
    .i_inv_all(inv_all), .o_valid_vec(c_vv), .o_occ_cnt(c_oc));

  dma_dsc_cache_ram #(.DATA_W(32), .DEPTH(16), .RD_LAT(1), .FWD_EN(1'b1)) u_d (
    .i_clk(clk), .i_srst_n(srst_n), .i_w_en(w_en), .i_w_addr(w_addr),
    .i_w_data(w_data), .i_r_en(r_en), .i_r_addr(r_addr), .o_r_data(d_rd),
    .o_r_valid(d_rv), .o_r_hit(d_rh), .i_inv_en(inv_en), .i_inv_addr(inv_addr),
    .i_inv_all(inv_all), .o_valid_vec(d_vv), .o_occ_cnt(d_oc));

  // Reference model: small (4 x 13) and large (16 x 32) caches, valid and "written" flags.
  typedef struct {logic v; logic h; logic [31:0] d; logic k;} rd_t;
  logic [12:0] sd [4];
  logic [31:0] ld [16];
  logic [3:0]  sv, sk;
  logic [15:0] lv, lk;
  rd_t ea, eb, ec1, ec2, ed, la, lb, lc, ll;

  function automatic int pop(input logic [15:0] v);
    int n = 0;
    for (int i = 0; i < 16; i++) if (v[i]) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic chk_rd(input string t, input rd_t e, input rd_t l,
                        input logic rv, input logic rh, input logic [31:0] rd);
    chk({t, "_rv"}, 64'(rv), 64'(e.v));
    chk({t, "_rh"}, 64'(rh), 64'(e.v && e.h));
    if (l.k) chk({t, "_rd"}, 64'(rd), 64'(l.d));
  endtask

  // One clock: predict read results from pre-edge state, apply edge, check every DUT.
  task automatic step();
    rd_t na, nb, nd;
    logic sc, lcol;
    logic [1:0] sr, sw;
    sr = r_addr[1:0];
    sw = w_addr[1:0];
    sc = w_en && (sw == sr);
    lcol = w_en && (w_addr == r_addr);
    na.v = r_en; na.h = sc || sv[sr]; na.k = sc || sk[sr];
    na.d = sc ? 32'(w_data[12:0]) : 32'(sd[sr]);
    nb.v = r_en; nb.h = sv[sr]; nb.k = sk[sr]; nb.d = 32'(sd[sr]);
    nd.v = r_en; nd.h = lcol || lv[r_addr]; nd.k = lcol || lk[r_addr];
    nd.d = lcol ? w_data : ld[r_addr];
    @(posedge clk);
    if (!srst_n) begin
      sv = '0; lv = '0;
      ea.v = 1'b0; eb.v = 1'b0; ec1.v = 1'b0; ec2.v = 1'b0; ed.v = 1'b0;
      la.v = 1'b0; la.h = 1'b0; la.d = '0; la.k = 1'b1;
      lb = la; lc = la; ll = la;
    end else begin
      ea = na; eb = nb; ec2 = ec1; ec1 = na; ed = nd;
      if (inv_all) begin sv = '0; lv = '0; end
      if (inv_en) begin sv[inv_addr[1:0]] = 1'b0; lv[inv_addr] = 1'b0; end
      if (w_en) begin
        sv[sw] = 1'b1; sk[sw] = 1'b1; sd[sw] = w_data[12:0];
        lv[w_addr] = 1'b1; lk[w_addr] = 1'b1; ld[w_addr] = w_data;
      end
    end
    if (ea.v) la = ea;
    if (eb.v) lb = eb;
    if (ec2.v) lc = ec2;
    if (ed.v) ll = ed;
    #1;
    chk_rd("a", ea, la, a_rv, a_rh, 32'(a_rd));
    chk_rd("b", eb, lb, b_rv, b_rh, 32'(b_rd));
    chk_rd("c", ec2, lc, c_rv, c_rh, 32'(c_rd));
    chk_rd("d", ed, ll, d_rv, d_rh, d_rd);
    chk("a_vv", 64'(a_vv), 64'(sv)); chk("a_oc", 64'(a_oc), 64'(pop(16'(sv))));
    chk("b_vv", 64'(b_vv), 64'(sv)); chk("c_oc", 64'(c_oc), 64'(pop(16'(sv))));
    chk("d_vv", 64'(d_vv), 64'(lv)); chk("d_oc", 64'(d_oc), 64'(pop(lv)));
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    w_en = 1'b1; w_addr = a; w_data = d;
    step();
    w_en = 1'b0;
  endtask

  initial begin
    srst_n = 1'b0; w_en = 1'b0; r_en = 1'b0; inv_en = 1'b0; inv_all = 1'b0;
    w_addr = '0; r_addr = '0; inv_addr = '0; w_data = '0;
    sv = '0; sk = '0; lv = '0; lk = '0;
    step(); step();
    chk("rst_oc", 64'(a_oc), 64'd0);
    chk("rst_rd", 64'(c_rd), 64'd0);
    srst_n = 1'b1;

    // read of an empty entry after reset
    r_en = 1'b1; r_addr = 4'd2; step();
    chk("t1_rv", 64'(a_rv), 64'd1); chk("t1_hit", 64'(a_rh), 64'd0);
    chk("t1_vv", 64'(a_vv), 64'b0000);
    r_en = 1'b0; step(); step();

    // write two entries, read back-to-back
    wr(4'd0, 32'h1A5); wr(4'd3, 32'h0F0);
    r_en = 1'b1; r_addr = 4'd0; step();
    chk("t2_rd0", 64'(a_rd), 64'h1A5); chk("t2_h0", 64'(a_rh), 64'd1);
    r_addr = 4'd3; step();
    chk("t2_rd3", 64'(a_rd), 64'h0F0); chk("t2_h3", 64'(a_rh), 64'd1);
    r_en = 1'b0; step(); step();
    chk("t2_vv", 64'(a_vv), 64'b1001); chk("t2_oc", 64'(a_oc), 64'd2);
    chk("t2_c_rd3", 64'(c_rd), 64'h0F0);

    // same-edge write/read collision
    wr(4'd1, 32'h155);
    w_en = 1'b1; w_addr = 4'd1; w_data = 32'h0AA; r_en = 1'b1; r_addr = 4'd1;
    step();
    chk("t3_fwd", 64'(a_rd), 64'h0AA); chk("t3_fwd_h", 64'(a_rh), 64'd1);
    chk("t3_nofwd", 64'(b_rd), 64'h155);
    w_en = 1'b0; r_en = 1'b0; step();
    chk("t3_hold", 64'(a_rd), 64'h0AA); chk("t3_c", 64'(c_rd), 64'h0AA);

    // global invalidate with concurrent write, then invalidate an already-invalid entry
    for (int i = 0; i < 4; i++) wr(4'(i), 32'h100 + 32'(i));
    chk("t4_full", 64'(a_oc), 64'd4);
    inv_all = 1'b1; w_en = 1'b1; w_addr = 4'd2; w_data = 32'h077; step();
    inv_all = 1'b0; w_en = 1'b0;
    chk("t4_vv", 64'(a_vv), 64'b0100); chk("t4_oc", 64'(a_oc), 64'd1);
    inv_en = 1'b1; inv_addr = 4'd3; step();
    inv_en = 1'b0;
    chk("t4_oc2", 64'(a_oc), 64'd1);
    for (int i = 0; i < 4; i++) wr(4'(i), 32'h1C0 + 32'(i));

    // reset in the middle of a stream of RD_LAT=2 reads
    for (int i = 0; i < 8; i++) begin
      r_en = 1'b1; r_addr = 4'(i % 4);
      srst_n = (i != 3);
      step();
      if (i == 3) begin
        chk("t5_rv_rst", 64'(c_rv), 64'd0); chk("t5_rd_rst", 64'(c_rd), 64'd0);
        chk("t5_oc_rst", 64'(c_oc), 64'd0);
      end
      if (i == 4) chk("t5_rv_after", 64'(c_rv), 64'd0);
    end
    r_en = 1'b0; srst_n = 1'b1; step(); step();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      w_en     = 1'($urandom_range(0, 1));
      r_en     = 1'($urandom_range(0, 1));
      inv_en   = ($urandom_range(0, 3) == 0);
      inv_all  = ($urandom_range(0, 31) == 0);
      w_addr   = 4'($urandom_range(0, 15));
      r_addr   = ($urandom_range(0, 3) == 0) ? w_addr : 4'($urandom_range(0, 15));
      inv_addr = 4'($urandom_range(0, 15));
      w_data   = $urandom;
      step();
    end
    w_en = 1'b0; r_en = 1'b0; inv_en = 1'b0; inv_all = 1'b0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
